// File: rtl/apb_ic_pkg.sv
// Shared types and widths for the APB interconnect blocks.
package apb_ic_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past ptr_i and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    // Walk from lowest to highest priority so the nearest set request overwrites.
    for (int off = NUM_REQ; off >= 1; off--) begin
      int cand;
      cand = (int'(ptr_i) + off) % NUM_REQ;
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
        valid_o     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin APB master: runs one requester's transfer at a time as SETUP/ACCESS, then a DONE gap.
module apb_rr_master_arbiter
  import apb_ic_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d, owner_q, owner_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, pwdata_q, pwdata_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                err_q, err_d, pwrite_q, pwrite_d;
  logic                psel_q, psel_d, penable_q, penable_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    tcnt_d   = tcnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d  = SETUP;
          gnt_d    = arb_gnt;
          owner_d  = arb_idx;
          pwrite_d = req_write[arb_idx];
          paddr_d  = req_addr[ADDR_W*arb_idx +: ADDR_W];
          pwdata_d = req_wdata[DATA_W*arb_idx +: DATA_W];
        end
      end
      SETUP: begin
        state_d = ACCESS;
        tcnt_d  = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d = DONE;
          done_d  = gnt_q;
          rdata_d = pwrite_q ? '0 : prdata;
          err_d   = pslverr;
        end else if (TIMEOUT != 0 && tcnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          done_d  = gnt_q;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = owner_q;
      end
      default: state_d = IDLE;
    endcase
    // Bus strobes are registered from the state being entered.
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      owner_q   <= '0;
      tcnt_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      tcnt_q    <= tcnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
endmodule
